// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, stall and redirect inputs, and the
// registered instruction handed to decode.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 28
);
  logic [ADDR_W-1:0]  oAddress;
  logic [INSTR_W-1:0] iInstruction;
  logic               iStall;
  logic               iBranchTaken;
  logic [ADDR_W-1:0]  iBranchTarget;
  logic [INSTR_W-1:0] oInstruction;
  logic [ADDR_W-1:0]  oPC;
  logic               oValid;

  modport master (
    output oAddress, oInstruction, oPC, oValid,
    input  iInstruction, iStall, iBranchTaken, iBranchTarget
  );

  modport slave (
    input  oAddress, oInstruction, oPC, oValid,
    output iInstruction, iStall, iBranchTaken, iBranchTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, registers ROM words for decode, resolves JMP
// without a bubble and turns NOP delay fields into timed fetch stalls.
module instruction_fetch #(
  parameter int              ADDR_W     = 16,
  parameter int              INSTR_W    = 28,
  parameter int              OP_W       = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [OP_W-1:0] OP_NOP     = 4'd0,
  parameter logic [OP_W-1:0] OP_JMP     = 4'd12
) (
  input  logic             Clock,
  input  logic             Reset,
  instruction_fetch_if.master bus
);
  localparam int DLY_W = INSTR_W - OP_W;

  typedef enum logic {S_FETCH, S_DELAY} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]  r_opc, w_opc_nxt;
  logic               r_valid, w_valid_nxt;
  logic [DLY_W-1:0]   r_dly_cnt, w_dly_cnt_nxt;

  logic [OP_W-1:0]    w_opcode;
  logic [DLY_W-1:0]   w_dly_field;

  assign w_opcode    = bus.iInstruction[INSTR_W-1 -: OP_W];
  assign w_dly_field = bus.iInstruction[DLY_W-1:0];

  // NOTE: every signal written here gets a default first so that no path
  // through the branches can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_opc_nxt     = r_opc;
    w_valid_nxt   = r_valid;
    w_dly_cnt_nxt = r_dly_cnt;

    if (bus.iBranchTaken) begin
      // Redirect beats both stall and a pending NOP delay.
      w_pc_nxt      = bus.iBranchTarget;
      w_valid_nxt   = 1'b0;
      w_state_nxt   = S_FETCH;
      w_dly_cnt_nxt = '0;
    end else if (!bus.iStall) begin
      unique case (r_state)
        S_FETCH: begin
          w_instr_nxt = bus.iInstruction;
          w_opc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          if (w_opcode == OP_JMP) w_pc_nxt = bus.iInstruction[ADDR_W-1:0];
          else                    w_pc_nxt = r_pc + ADDR_W'(1);
          if (w_opcode == OP_NOP && w_dly_field != '0) begin
            w_dly_cnt_nxt = w_dly_field;
            w_state_nxt   = S_DELAY;
          end
        end
        S_DELAY: begin
          w_valid_nxt   = 1'b0;
          w_dly_cnt_nxt = r_dly_cnt - DLY_W'(1);
          if (r_dly_cnt == DLY_W'(1)) w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_ADDR;
      r_instr   <= '0;
      r_opc     <= '0;
      r_valid   <= 1'b0;
      r_dly_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_opc     <= w_opc_nxt;
      r_valid   <= w_valid_nxt;
      r_dly_cnt <= w_dly_cnt_nxt;
    end
  end

  assign bus.oAddress     = r_pc;
  assign bus.oInstruction = r_instr;
  assign bus.oPC          = r_opc;
  assign bus.oValid       = r_valid;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural ROM feeds the stage,
// expected (PC, word, preceding bubble count) entries are queued per scenario.
module tb_instruction_fetch;
  localparam int         ADDR_W  = 16;
  localparam int         INSTR_W = 28;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd12;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    int                 gap;
    int                 bub_addr;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  logic [INSTR_W-1:0] rom [0:65535];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instruction_fetch #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OP_W(4),
    .RESET_ADDR(16'd0), .OP_NOP(OP_NOP), .OP_JMP(OP_JMP)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.master)
  );

  always #5 Clock = ~Clock;
  always_comb bus.iInstruction = rom[bus.oAddress];

  function automatic logic [INSTR_W-1:0] word(input logic [15:0] a);
    return {4'h5, 8'h3C, a};
  endfunction
  function automatic logic [INSTR_W-1:0] nop(input logic [23:0] d);
    return {OP_NOP, d};
  endfunction
  function automatic logic [INSTR_W-1:0] jmp(input logic [15:0] t);
    return {OP_JMP, 8'h00, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [INSTR_W-1:0] instr,
                      input int gap, input int bub_addr);
    exp_t e;
    e.pc = pc; e.instr = instr; e.gap = gap; e.bub_addr = bub_addr;
    exp_q.push_back(e);
  endtask

  // Run until every queued entry has been seen, counting bubbles before each.
  task automatic drain(input int budget);
    int   gap = 0;
    int   bad_addr = 0;
    int   cyc = 0;
    exp_t e;
    while (exp_q.size() > 0 && cyc < budget) begin
      step();
      cyc++;
      if (bus.oValid !== 1'b1) begin
        gap++;
        if (exp_q[0].bub_addr >= 0 && bus.oAddress !== exp_q[0].bub_addr[15:0]) bad_addr++;
      end else begin
        e = exp_q.pop_front();
        check("oPC", 32'(bus.oPC), 32'(e.pc));
        check("oInstruction", 32'(bus.oInstruction), 32'(e.instr));
        check("bubbles", gap, e.gap);
        if (e.bub_addr >= 0) check("bubble_oAddress_errs", bad_addr, 0);
        gap = 0;
        bad_addr = 0;
      end
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = word(16'(i));
    Reset             = 1'b0;
    bus.iStall        = 1'b0;
    bus.iBranchTaken  = 1'b0;
    bus.iBranchTarget = '0;

    // Reset for two edges
    step();
    check("rst_oAddress", 32'(bus.oAddress), 0);
    step();
    check("rst_oAddress", 32'(bus.oAddress), 0);
    check("rst_oValid", 32'(bus.oValid), 0);
    check("rst_oPC", 32'(bus.oPC), 0);
    check("rst_oInstruction", 32'(bus.oInstruction), 0);
    Reset = 1'b1;
    for (int a = 0; a < 4; a++) push(16'(a), word(16'(a)), 0, -1);
    drain(20);

    // JMP at 5 back to 0, no bubble
    rom[5] = jmp(16'h0000);
    push(16'd4, word(16'd4), 0, -1);
    push(16'd5, jmp(16'h0000), 0, -1);
    push(16'd0, word(16'd0), 0, -1);
    push(16'd1, word(16'd1), 0, -1);
    push(16'd2, word(16'd2), 0, -1);
    drain(20);

    // Stall three cycles while oPC=2
    bus.iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_oPC", 32'(bus.oPC), 2);
      check("stall_oValid", 32'(bus.oValid), 1);
      check("stall_oInstruction", 32'(bus.oInstruction), 32'(word(16'd2)));
      check("stall_oAddress", 32'(bus.oAddress), 3);
    end
    bus.iStall = 1'b0;
    push(16'd3, word(16'd3), 0, -1);
    drain(5);

    // Redirect to 1 where a NOP with D=4000 sits
    rom[1] = nop(24'd4000);
    bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'd1;
    step();
    bus.iBranchTaken = 1'b0;
    check("br_oValid", 32'(bus.oValid), 0);
    check("br_oAddress", 32'(bus.oAddress), 1);
    push(16'd1, nop(24'd4000), 0, -1);
    push(16'd2, word(16'd2), 4000, 2);
    drain(4100);

    // D=1 gives one bubble, D=0 none; JMP at 5 wraps to 0, then NOP D=5 at 1
    rom[3] = nop(24'd1);
    rom[4] = nop(24'd0);
    rom[1] = nop(24'd5);
    push(16'd3, nop(24'd1), 0, -1);
    push(16'd4, nop(24'd0), 1, 4);
    push(16'd5, jmp(16'h0000), 0, -1);
    push(16'd0, word(16'd0), 0, -1);
    push(16'd1, nop(24'd5), 0, -1);
    drain(20);

    // Stall mid-delay: 5 bubbles stretch to 8
    step(); step();
    bus.iStall = 1'b1;
    step(); step(); step();
    check("dly_stall_oValid", 32'(bus.oValid), 0);
    check("dly_stall_oAddress", 32'(bus.oAddress), 2);
    bus.iStall = 1'b0;
    push(16'd2, word(16'd2), 3, 2);
    drain(20);

    // Branch with stall during a long delay cancels the rest of it
    rom[3] = nop(24'd100);
    push(16'd3, nop(24'd100), 0, -1);
    drain(5);
    step(); step();
    bus.iStall = 1'b1; bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'h0010;
    step();
    bus.iStall = 1'b0; bus.iBranchTaken = 1'b0;
    check("br_dly_oValid", 32'(bus.oValid), 0);
    check("br_dly_oAddress", 32'(bus.oAddress), 32'h10);
    push(16'h0010, word(16'h0010), 0, -1);
    drain(5);

    // PC wrap at 16'hFFFF
    bus.iBranchTaken = 1'b1; bus.iBranchTarget = 16'hFFFF;
    step();
    bus.iBranchTaken = 1'b0;
    push(16'hFFFF, word(16'hFFFF), 0, -1);
    drain(5);
    check("wrap_oAddress", 32'(bus.oAddress), 0);
    push(16'h0000, word(16'h0000), 0, -1);
    push(16'd1, nop(24'd5), 0, -1);
    drain(5);

    // Reset in the middle of a delay
    step();
    Reset = 1'b0;
    step();
    check("rst_dly_oValid", 32'(bus.oValid), 0);
    check("rst_dly_oPC", 32'(bus.oPC), 0);
    check("rst_dly_oInstruction", 32'(bus.oInstruction), 0);
    check("rst_dly_oAddress", 32'(bus.oAddress), 0);
    Reset = 1'b1;
    push(16'h0000, word(16'h0000), 0, -1);
    drain(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
